// File: rtl/regfile_rat_if.sv
// Dispatch/ROB/CDB-facing port bundle for the renaming register file.
// master = ROB/dispatch side driving requests, slave = register file.
interface regfile_rat_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
);
  logic              alloc_valid;
  logic [4:0]        alloc_rd;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              commit_valid;
  logic [4:0]        commit_rd;
  logic [TAG_W-1:0]  commit_tag;
  logic              commit_sel;
  logic [DATA_W-1:0] dmem_rdata;
  logic              flush;
  logic [4:0]        rs1_idx;
  logic [4:0]        rs2_idx;
  logic              rs1_ready;
  logic [DATA_W-1:0] rs1_value;
  logic [TAG_W-1:0]  rs1_tag;
  logic              rs2_ready;
  logic [DATA_W-1:0] rs2_value;
  logic [TAG_W-1:0]  rs2_tag;
  logic [4:0]        st_src;
  logic [DATA_W-1:0] st_data;

  modport master (
    output alloc_valid, alloc_rd, alloc_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output commit_valid, commit_rd, commit_tag, commit_sel, dmem_rdata,
    output flush, rs1_idx, rs2_idx, st_src,
    input  rs1_ready, rs1_value, rs1_tag,
    input  rs2_ready, rs2_value, rs2_tag, st_data
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  commit_valid, commit_rd, commit_tag, commit_sel, dmem_rdata,
    input  flush, rs1_idx, rs2_idx, st_src,
    output rs1_ready, rs1_value, rs1_tag,
    output rs2_ready, rs2_value, rs2_tag, st_data
  );
endinterface

// File: rtl/regfile_rat.sv
// Architectural register file with ROB-tag renaming and an 8-entry result buffer
// that holds CDB results until commit; source reads resolve value or wait tag.
module regfile_rat #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic           clk,
  input  logic           rst,
  regfile_rat_if.slave   bus_io
);

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  tag;
  } rd_res_t;

  logic [DATA_W-1:0]    data_q     [NUM_REGS];
  logic [DATA_W-1:0]    data_d     [NUM_REGS];
  logic [TAG_W-1:0]     tag_q      [NUM_REGS];
  logic [TAG_W-1:0]     tag_d      [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;
  logic [DATA_W-1:0]    vb_data_q  [ROB_DEPTH];
  logic [DATA_W-1:0]    vb_data_d  [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] vb_valid_q;
  logic [ROB_DEPTH-1:0] vb_valid_d;

  logic [DATA_W-1:0]    commit_val_s;
  rd_res_t              rs1_res_s;
  rd_res_t              rs2_res_s;

  // Source lookup: committed value, buffered result, same-cycle CDB bypass, else wait on tag.
  function automatic rd_res_t read_src(
    input logic [4:0]        idx,
    input logic              cdb_v,
    input logic [TAG_W-1:0]  cdb_t,
    input logic [DATA_W-1:0] cdb_d
  );
    rd_res_t          r;
    logic [TAG_W-1:0] t;
    t       = tag_q[idx];
    r.ready = 1'b1;
    r.value = '0;
    r.tag   = '0;
    if (idx == 5'd0) begin
      r.ready = 1'b1;
    end else if (!busy_q[idx]) begin
      r.value = data_q[idx];
      r.tag   = t;
    end else if (vb_valid_q[t]) begin
      r.value = vb_data_q[t];
      r.tag   = t;
    end else if (cdb_v && (cdb_t == t)) begin
      r.value = cdb_d;
      r.tag   = t;
    end else begin
      r.ready = 1'b0;
      r.tag   = t;
    end
    return r;
  endfunction

  // Value retired by this cycle's commit, including a result arriving on the CDB right now.
  always_comb begin
    commit_val_s = vb_data_q[bus_io.commit_tag];
    if (bus_io.commit_sel) begin
      commit_val_s = bus_io.dmem_rdata;
    end else if (vb_valid_q[bus_io.commit_tag]) begin
      commit_val_s = vb_data_q[bus_io.commit_tag];
    end else if (bus_io.cdb_valid && (bus_io.cdb_tag == bus_io.commit_tag)) begin
      commit_val_s = bus_io.cdb_data;
    end else begin
      commit_val_s = vb_data_q[bus_io.commit_tag];
    end
  end

  // Next-state: commit first so a same-cycle allocate to the same rd keeps it busy.
  always_comb begin
    data_d     = data_q;
    tag_d      = tag_q;
    busy_d     = busy_q;
    vb_data_d  = vb_data_q;
    vb_valid_d = vb_valid_q;

    if (bus_io.commit_valid && (bus_io.commit_rd != 5'd0)) begin
      data_d[bus_io.commit_rd] = commit_val_s;
      if (tag_q[bus_io.commit_rd] == bus_io.commit_tag) begin
        busy_d[bus_io.commit_rd] = 1'b0;
      end else begin
        busy_d[bus_io.commit_rd] = busy_q[bus_io.commit_rd];
      end
    end else begin
      data_d = data_q;
    end

    if (bus_io.flush) begin
      busy_d     = '0;
      vb_valid_d = '0;
    end else begin
      if (bus_io.alloc_valid && (bus_io.alloc_rd != 5'd0)) begin
        busy_d[bus_io.alloc_rd]     = 1'b1;
        tag_d[bus_io.alloc_rd]      = bus_io.alloc_tag;
        vb_valid_d[bus_io.alloc_tag] = 1'b0;
      end else begin
        tag_d = tag_q;
      end
      // CDB is applied after allocate so it wins on a tag collision.
      if (bus_io.cdb_valid) begin
        vb_data_d[bus_io.cdb_tag]  = bus_io.cdb_data;
        vb_valid_d[bus_io.cdb_tag] = 1'b1;
      end else begin
        vb_data_d = vb_data_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '{default: '0};
      tag_q      <= '{default: '0};
      busy_q     <= '0;
      vb_data_q  <= '{default: '0};
      vb_valid_q <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      vb_data_q  <= vb_data_d;
      vb_valid_q <= vb_valid_d;
    end
  end

  // Read ports see pre-clock state plus the live CDB.
  always_comb begin
    rs1_res_s = read_src(bus_io.rs1_idx, bus_io.cdb_valid, bus_io.cdb_tag, bus_io.cdb_data);
    rs2_res_s = read_src(bus_io.rs2_idx, bus_io.cdb_valid, bus_io.cdb_tag, bus_io.cdb_data);
    bus_io.rs1_ready = rs1_res_s.ready;
    bus_io.rs1_value = rs1_res_s.value;
    bus_io.rs1_tag   = rs1_res_s.tag;
    bus_io.rs2_ready = rs2_res_s.ready;
    bus_io.rs2_value = rs2_res_s.value;
    bus_io.rs2_tag   = rs2_res_s.tag;
    if (bus_io.st_src == 5'd0) begin
      bus_io.st_data = '0;
    end else begin
      bus_io.st_data = data_q[bus_io.st_src];
    end
  end

endmodule
